// File: rtl/mem_ctrl_if.sv
// Request/response bus between a client and mem_ctrl.
// The controller takes the slave side; the client (or bench) drives the master side.
interface mem_ctrl_if #(
    parameter int PA_WIDTH   = 32,
    parameter int REG_WIDTH  = 32,
    parameter int LINE_WIDTH = 128,
    parameter int ID_WIDTH   = 2
);
    logic                  req_enable;
    logic                  req_write;
    logic [PA_WIDTH-1:0]   req_addr;
    logic [REG_WIDTH-1:0]  req_data;
    logic [ID_WIDTH-1:0]   req_id;
    logic                  full;
    logic                  resp_enable;
    logic [LINE_WIDTH-1:0] resp_data;
    logic [ID_WIDTH-1:0]   resp_id;
    logic                  ack;

    modport master (
        output req_enable, req_write, req_addr, req_data, ack,
        input  req_id, full, resp_enable, resp_data, resp_id
    );

    modport slave (
        input  req_enable, req_write, req_addr, req_data, ack,
        output req_id, full, resp_enable, resp_data, resp_id
    );
endinterface

// File: rtl/mem_ctrl.sv
// In-order memory controller: a request FIFO feeds a serial service FSM that
// stores single words into a line-wide backing store or returns whole lines.
module mem_ctrl #(
    parameter int PA_WIDTH    = 32,
    parameter int REG_WIDTH   = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int ID_WIDTH    = 2,
    parameter int MEM_LINES   = 256,
    parameter int LATENCY     = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    localparam int LINE_BYTES = LINE_WIDTH / 8;
    localparam int WORD_BYTES = REG_WIDTH / 8;
    localparam int WORDS      = LINE_WIDTH / REG_WIDTH;
    localparam int OFF_BITS   = $clog2(LINE_BYTES);
    localparam int WB_BITS    = $clog2(WORD_BYTES);
    localparam int WIDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LIDX_W     = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int QP_W       = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W      = $clog2(QUEUE_DEPTH + 1);
    localparam int LAT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      count;
    logic [QP_W-1:0]       wr_ptr;
    logic [QP_W-1:0]       rd_ptr;
    logic [ID_WIDTH-1:0]   id_cnt;
    logic [LAT_W-1:0]      lat_cnt;
    logic [LIDX_W-1:0]     cur_line;
    logic [WIDX_W-1:0]     cur_word;
    logic [REG_WIDTH-1:0]  cur_data;
    logic [ID_WIDTH-1:0]   cur_id;
    logic                  resp_enable_q;
    logic [LINE_WIDTH-1:0] resp_data_q;
    logic [ID_WIDTH-1:0]   resp_id_q;

    logic                  q_write [QUEUE_DEPTH];
    logic [LIDX_W-1:0]     q_line  [QUEUE_DEPTH];
    logic [WIDX_W-1:0]     q_word  [QUEUE_DEPTH];
    logic [REG_WIDTH-1:0]  q_data  [QUEUE_DEPTH];
    logic [ID_WIDTH-1:0]   q_id    [QUEUE_DEPTH];

    logic [LINE_WIDTH-1:0] mem [MEM_LINES];

    logic                  push;
    logic                  pop;
    logic                  empty;
    logic [LIDX_W-1:0]     in_line;
    logic [WIDX_W-1:0]     in_word;
    logic                  addr_unused;

    // Addresses are decoded once on entry; the line index wraps modulo MEM_LINES.
    assign in_line = bus.req_addr[OFF_BITS +: LIDX_W];

    generate
        if (WORDS > 1) begin : g_word_idx
            assign in_word = bus.req_addr[WB_BITS +: WIDX_W];
        end else begin : g_single_word
            assign in_word = '0;
        end
    endgenerate

    assign addr_unused = ^bus.req_addr;

    assign empty           = (count == '0);
    assign bus.full        = (count == CNT_W'(QUEUE_DEPTH));
    assign push            = bus.req_enable && !bus.full;
    assign pop             = (state == ST_IDLE) && !empty;
    assign bus.req_id      = id_cnt;
    assign bus.resp_enable = resp_enable_q;
    assign bus.resp_data   = resp_data_q;
    assign bus.resp_id     = resp_id_q;

    function automatic logic [QP_W-1:0] next_ptr(input logic [QP_W-1:0] p);
        return (p == QP_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            q_write[wr_ptr] <= bus.req_write;
            q_line[wr_ptr]  <= in_line;
            q_word[wr_ptr]  <= in_word;
            q_data[wr_ptr]  <= bus.req_data;
            q_id[wr_ptr]    <= id_cnt;
        end
    end

    // Backing store survives reset; a store caught by reset is abandoned.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_WRITE) begin
            mem[cur_line][cur_word*REG_WIDTH +: REG_WIDTH] <= cur_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            count         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            id_cnt        <= '0;
            lat_cnt       <= '0;
            cur_line      <= '0;
            cur_word      <= '0;
            cur_data      <= '0;
            cur_id        <= '0;
            resp_enable_q <= 1'b0;
            resp_data_q   <= '0;
            resp_id_q     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
                id_cnt <= id_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        cur_line <= q_line[rd_ptr];
                        cur_word <= q_word[rd_ptr];
                        cur_data <= q_data[rd_ptr];
                        cur_id   <= q_id[rd_ptr];
                        lat_cnt  <= LAT_W'(LATENCY - 1);
                        state    <= q_write[rd_ptr] ? ST_WRITE : ST_WAIT;
                    end
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                end
                ST_WAIT: begin
                    // Earlier stores have all retired by now, so the line is current.
                    if (lat_cnt == '0) begin
                        resp_data_q   <= mem[cur_line];
                        resp_id_q     <= cur_id;
                        resp_enable_q <= 1'b1;
                        state         <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.ack) begin
                        resp_enable_q <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameters: PA_WIDTH (32, physical address bits); REG_WIDTH (32, store word bits); LINE_WIDTH (128, refill line bits, multiple of REG_WIDTH); ID_WIDTH (2, transaction ID bits); MEM_LINES (256, backing-store lines, power of 2); LATENCY (4, read cycles, >=1); QUEUE_DEPTH (4, pending-request FIFO entries, power of 2).
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous and active-high.
REQ-003 SHALL have ports: i_req_enable in 1 request valid; i_req_write in 1 1=word store, 0=line read; i_req_addr in PA_WIDTH byte address; i_req_data in REG_WIDTH store data.
REQ-004 SHALL have ports: o_req_id out ID_WIDTH ID assigned to the request accepted this cycle; o_full out 1 FIFO full, no request is accepted.
REQ-005 SHALL have ports: o_resp_enable out 1 read response valid; o_resp_data out LINE_WIDTH line data; o_resp_id out ID_WIDTH ID of the response; i_ack in 1 consumer accepts the response.

Function
REQ-006 SHALL accept a request when i_req_enable=1 and o_full=0; o_full is derived from the registered FIFO count only, with no same-cycle bypass on dequeue.
REQ-007 SHALL assign IDs from a counter that starts at 0 and increments by 1 per accepted request, modulo 2^ID_WIDTH; o_req_id always shows the counter value.
REQ-008 SHALL hold, per FIFO entry: write flag, address, data and ID; requests are serviced strictly in acceptance order.
REQ-009 SHALL decode addresses as follows: line index = addr bits above the line offset, modulo MEM_LINES; word index = addr[log2(LINE_WIDTH/8)-1 : log2(REG_WIDTH/8)]; lower byte bits ignored.
REQ-010 SHALL run a service FSM with states IDLE, WRITE, WAIT, RESP.
REQ-011 IDLE: if FIFO non-empty, pop the head; go to WRITE for a store or WAIT for a read, loading the latency counter with LATENCY-1.
REQ-012 WRITE: update the addressed word of the line on the next clock edge; other words unchanged; no response generated; return to IDLE (2 cycles per store).
REQ-013 WAIT: decrement the counter each cycle; at 0, capture the full line into o_resp_data, set o_resp_id to the request ID, and go to RESP.
REQ-014 RESP: o_resp_enable=1, with data and id stable until i_ack=1; on ack, go to IDLE; i_ack outside RESP is ignored.
REQ-015 SHALL return the read data as the line content after all earlier-accepted stores have completed (read-after-write in order).
REQ-016 SHALL allow a push and an FIFO pop in the same cycle, leaving the count unchanged; a request with i_req_enable=1 while o_full=1 is dropped and the ID counter does not advance.
REQ-017 SHALL wrap FIFO read and write pointers modulo QUEUE_DEPTH.
REQ-018 SHALL achieve a minimum read latency, accept to o_resp_enable, of LATENCY+2 cycles (enqueue, IDLE pop, LATENCY WAIT cycles).

Reset
REQ-019 On rst=1 at a clock edge, SHALL set: FSM to IDLE; FIFO empty; ID counter 0; o_full=0; o_resp_enable=0; o_resp_data=0; o_resp_id=0.
REQ-020 Reset mid-transaction SHALL discard any in-flight or queued requests with no response; backing-store contents are not cleared by reset.
REQ-021 SHALL ignore requests presented while rst=1.

Verification
REQ-022 Store then read: write 0xDEADBEEF to 0x10, then read 0x10 -> response with word 0 of line 1 = 0xDEADBEEF, ID 1, o_resp_enable asserted LATENCY+2 cycles after the read is accepted when the FSM is idle.
REQ-023 Back-pressure: read issued with i_ack held at 0 for 10 cycles -> o_resp_enable, o_resp_data and o_resp_id stable for all 10 cycles; released the cycle after ack.
REQ-024 Full: 5 reads in consecutive cycles with QUEUE_DEPTH=4 while in RESP without ack -> o_full=1 after the 4th, 5th dropped, IDs 0..3 then counter stays 0 (mod 4 wrap) after the drop.
REQ-025 ID wrap: 6 reads with ID_WIDTH=2 -> responses in order with IDs 0,1,2,3,0,1.
REQ-026 Reset mid-WAIT: rst pulsed during WAIT -> no response; o_full=0; the next read gets ID 0 and returns the previously stored data.
